// File: rtl/serial_sub_defs.sv
// Shared constants for the bit-serial subtractor: FSM encodings and default width.
package serial_sub_defs;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fs_cell.sv
// Single-bit full subtractor: d = x - y - bin, bo set when the bit borrows.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bin;
    assign bo = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one bit per cycle, LSB first, through a single fs_cell.
module serial_sub
    import serial_sub_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // Handshake: start is sampled only while busy=0; the operands are captured on
    // that same edge. busy stays high until the cycle after the one-cycle done pulse,
    // and diff/bout are valid (and stable) from done until the next completion.

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] ar_sh;
    logic [WIDTH-1:0] b_sh;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             cell_d;
    logic             cell_bo;
    logic             last_bit;

    fs_cell u_cell (
        .x   (ar_sh[0]),
        .y   (b_sh[0]),
        .bin (borrow),
        .d   (cell_d),
        .bo  (cell_bo)
    );

    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // The minuend register doubles as the result register: each consumed minuend
    // bit leaves at the LSB while the new difference bit enters at the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_sh  <= '0;
            b_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ar_sh  <= a;
                        b_sh   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    ar_sh  <= {cell_d, ar_sh[WIDTH-1:1]};
                    b_sh   <= b_sh >> 1;
                    borrow <= cell_bo;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        diff <= {cell_d, ar_sh[WIDTH-1:1]};
                        bout <= cell_bo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
